// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths, FSM state and owner codes for the dmem arbiter
package dmem_arbiter_pkg;
  localparam int DMEM_ADDR_W = 24;
  localparam int DMEM_DATA_W = 24;
  typedef enum logic {ARB_IDLE, ARB_RD} arb_state_e;
  typedef enum logic {ARB_OWN_CPU, ARB_OWN_DBG} arb_own_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: cpu, debug and dmem bus signals around the dmem arbiter
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arb_starve.sv
// dmem_arb_starve: cpu-first priority pick with a saturating counter that forces dbg through
module dmem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic r_clk,
  input  logic rst_n,
  input  logic can_gnt,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic cpu_win,
  output logic dbg_win
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt;
  assign dbg_win = can_gnt & dbg_req & (~cpu_req | (cnt == CW'(STARVE_MAX)));
  assign cpu_win = can_gnt & cpu_req & ~dbg_win;
  always_ff @(posedge r_clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!dbg_req || dbg_win) cnt <= '0;
    else if (cpu_win && cnt != CW'(STARVE_MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the cpu MA stage and the debug port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic           r_clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int LW = $clog2(MEM_LAT + 1);
  arb_state_e    state, state_nx;
  arb_own_e      owner, owner_nx;
  logic [LW-1:0] cnt, cnt_nx;
  logic          last, can_gnt, cpu_win, dbg_win, win, we_sel, rd_go;
  // the rvalid cycle is also a grant slot, giving back-to-back reads
  assign last    = state == ARB_RD && cnt == LW'(1);
  assign can_gnt = rst_n && (state == ARB_IDLE || last);
  dmem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .r_clk   (r_clk),
    .rst_n   (rst_n),
    .can_gnt (can_gnt),
    .cpu_req (bus.cpu_req),
    .dbg_req (bus.dbg_req),
    .cpu_win (cpu_win),
    .dbg_win (dbg_win)
  );
  assign win           = cpu_win | dbg_win;
  assign we_sel        = dbg_win ? bus.dbg_we : cpu_win & bus.cpu_we;
  assign rd_go         = win & ~we_sel;
  assign bus.cpu_gnt   = cpu_win;
  assign bus.dbg_gnt   = dbg_win;
  assign bus.mem_en    = win;
  assign bus.mem_we    = we_sel;
  assign bus.mem_addr  = dbg_win ? bus.dbg_addr : cpu_win ? bus.cpu_addr : '0;
  assign bus.mem_wdata = dbg_win ? bus.dbg_wdata : cpu_win ? bus.cpu_wdata : '0;
  assign bus.cpu_rvalid = last && owner == ARB_OWN_CPU;
  assign bus.dbg_rvalid = last && owner == ARB_OWN_DBG;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;
  // a cpu read holds the pipe from its grant until the cycle before rvalid
  assign bus.cpu_stall = rst_n & ((bus.cpu_req & ~cpu_win) | (cpu_win & ~bus.cpu_we) |
                                  (state == ARB_RD && owner == ARB_OWN_CPU && !last));
  always_comb begin
    state_nx = rd_go ? ARB_RD : last ? ARB_IDLE : state;
    cnt_nx   = rd_go ? LW'(MEM_LAT) : state == ARB_RD ? cnt - 1'b1 : cnt;
    owner_nx = rd_go ? (dbg_win ? ARB_OWN_DBG : ARB_OWN_CPU) : owner;
  end
  always_ff @(posedge r_clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB_IDLE;
      cnt   <= '0;
      owner <= ARB_OWN_CPU;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      owner <= owner_nx;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of two arbiters (MEM_LAT 1 and 3) against a timestamp model
module tb_dmem_arbiter;
  localparam int SMAX = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        cr [2], cw [2], dr [2], dw [2];
  logic [23:0] ca [2], cd [2], da [2], dd [2];
  logic [31:0] ogc [2], ogd [2], orvc [2], orvd [2], ordc [2], ordd [2], ostl [2];
  logic [31:0] omen [2], omwe [2], omad [2], omwd [2];
  for (genvar g = 0; g < 2; g++) begin : gd
    dmem_arbiter_if bus ();
    dmem_arbiter #(.MEM_LAT(g ? 3 : 1), .STARVE_MAX(SMAX)) dut (
      .r_clk (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
    logic [23:0] em [256];
    logic [23:0] pipe [3];
    assign bus.cpu_req   = cr[g];
    assign bus.cpu_we    = cw[g];
    assign bus.cpu_addr  = ca[g];
    assign bus.cpu_wdata = cd[g];
    assign bus.dbg_req   = dr[g];
    assign bus.dbg_we    = dw[g];
    assign bus.dbg_addr  = da[g];
    assign bus.dbg_wdata = dd[g];
    assign bus.mem_rdata = pipe[g ? 2 : 0];
    assign ogc[g]  = 32'(bus.cpu_gnt);
    assign ogd[g]  = 32'(bus.dbg_gnt);
    assign orvc[g] = 32'(bus.cpu_rvalid);
    assign orvd[g] = 32'(bus.dbg_rvalid);
    assign ordc[g] = 32'(bus.cpu_rdata);
    assign ordd[g] = 32'(bus.dbg_rdata);
    assign ostl[g] = 32'(bus.cpu_stall);
    assign omen[g] = 32'(bus.mem_en);
    assign omwe[g] = 32'(bus.mem_we);
    assign omad[g] = 32'(bus.mem_addr);
    assign omwd[g] = 32'(bus.mem_wdata);
    // memory environment: cleared while reset is held, read data delayed by the latency
    always @(posedge clk) begin
      if (!rst_n) for (int i = 0; i < 256; i++) em[i] <= '0;
      else if (bus.mem_en && bus.mem_we) em[bus.mem_addr[7:0]] <= bus.mem_wdata;
      pipe[0] <= em[bus.mem_addr[7:0]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end
  int passes = 0, fails = 0, total = 0, now = 0;
  int pend [2], ret [2], pown [2], stv [2];
  logic        hold [2];
  logic [23:0] pdat [2];
  logic [23:0] sh [2][256];
  logic [9:0]  pat;
  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s dut%0d obs=%h exp=%h cyc=%0d", tag, d, obs, exp, now);
    end
  endtask
  function automatic int lat(input int d);
    return d ? 3 : 1;
  endfunction
  task automatic cpu(input int d, input logic r, input logic w, input logic [23:0] a, input logic [23:0] wd);
    cr[d] = r; cw[d] = w; ca[d] = a; cd[d] = wd;
  endtask
  task automatic dbg(input int d, input logic r, input logic w, input logic [23:0] a, input logic [23:0] wd);
    dr[d] = r; dw[d] = w; da[d] = a; dd[d] = wd;
  endtask
  task automatic quiet();
    for (int d = 0; d < 2; d++) begin
      cpu(d, 1'b0, 1'b0, 24'h0, 24'h0);
      dbg(d, 1'b0, 1'b0, 24'h0, 24'h0);
    end
  endtask
  // one clock: check both DUTs against the model, advance the model, move to the next low phase
  task automatic cyc();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic can, egc, egd, rv, gw;
      logic [23:0] ga, gwd;
      can = rst_n && (pend[d] == 0 || ret[d] == now);
      egd = can && dr[d] && (!cr[d] || stv[d] == SMAX);
      egc = can && cr[d] && !egd;
      rv  = rst_n && pend[d] != 0 && ret[d] == now;
      gw  = egd ? dw[d] : cw[d];
      ga  = egd ? da[d] : ca[d];
      gwd = egd ? dd[d] : cd[d];
      chk("cpu_gnt", d, ogc[d], 32'(egc));
      chk("dbg_gnt", d, ogd[d], 32'(egd));
      chk("mem_en", d, omen[d], 32'(egc || egd));
      if (egc || egd || !rst_n) begin
        chk("mem_we", d, omwe[d], 32'(rst_n && gw));
        chk("mem_addr", d, omad[d], 32'(rst_n ? ga : 24'd0));
        chk("mem_wdata", d, omwd[d], 32'(rst_n ? gwd : 24'd0));
      end
      chk("cpu_rvalid", d, orvc[d], 32'(rv && pown[d] == 0));
      chk("dbg_rvalid", d, orvd[d], 32'(rv && pown[d] == 1));
      if (rv && pown[d] == 0) chk("cpu_rdata", d, ordc[d], 32'(pdat[d]));
      if (rv && pown[d] == 1) chk("dbg_rdata", d, ordd[d], 32'(pdat[d]));
      if (!rst_n) begin
        chk("rst_cpu_rdata", d, ordc[d], 32'h0);
        chk("rst_dbg_rdata", d, ordd[d], 32'h0);
      end
      chk("cpu_stall", d, ostl[d], 32'(rst_n && ((cr[d] && !egc) || (egc && !cw[d]) ||
                                                (pend[d] != 0 && pown[d] == 0 && ret[d] > now))));
      if (!rst_n) begin
        pend[d] = 0;
        stv[d] = 0;
        hold[d] = 1'b0;
        for (int i = 0; i < 256; i++) sh[d][i] = '0;
      end else begin
        if (!dr[d] || egd) stv[d] = 0;
        else if (egc && stv[d] < SMAX) stv[d]++;
        if (rv) pend[d] = 0;
        if (egc || egd) begin
          if (gw) sh[d][ga[7:0]] = gwd;
          else begin
            pend[d] = 1;
            ret[d]  = now + lat(d);
            pown[d] = egd ? 1 : 0;
            pdat[d] = sh[d][ga[7:0]];
          end
        end
        hold[d] = cr[d] && !egc;
      end
    end
    now++;
    @(negedge clk);
  endtask
  // let any losing cpu request complete, then release all requests
  task automatic drain();
    for (int d = 0; d < 2; d++) dr[d] = 1'b0;
    for (int n = 0; n < 8 && (hold[0] || hold[1]); n++) cyc();
    chk("drain", 0, 32'({hold[0], hold[1]}), 32'h0);
    quiet();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      pend[d] = 0; ret[d] = 0; pown[d] = 0; stv[d] = 0; hold[d] = 1'b0; pdat[d] = '0;
    end
    quiet();
    @(negedge clk);
    cpu(0, 1'b1, 1'b0, 24'h7, 24'h0);
    dbg(1, 1'b1, 1'b0, 24'h7, 24'h0);
    #1;
    chk("rst_cpu_gnt", 0, ogc[0], 32'h0);
    chk("rst_cpu_stall", 0, ostl[0], 32'h0);
    chk("rst_dbg_gnt", 1, ogd[1], 32'h0);
    chk("rst_mem_en", 1, omen[1], 32'h0);
    quiet();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    // cpu write then read at MEM_LAT=1
    cpu(0, 1'b1, 1'b1, 24'h5, 24'h00ABCD);
    #1;
    chk("t2_wr_gnt", 0, ogc[0], 32'h1);
    chk("t2_wr_stall", 0, ostl[0], 32'h0);
    cyc();
    cpu(0, 1'b1, 1'b0, 24'h5, 24'h0);
    #1;
    chk("t2_rd_gnt", 0, ogc[0], 32'h1);
    chk("t2_rd_stall", 0, ostl[0], 32'h1);
    cyc();
    quiet();
    #1;
    chk("t2_rvalid", 0, orvc[0], 32'h1);
    chk("t2_rdata", 0, ordc[0], 32'h00ABCD);
    chk("t2_rv_stall", 0, ostl[0], 32'h0);
    cyc();
    // back-to-back reads of addresses 1..3
    for (int i = 1; i <= 3; i++) begin
      cpu(0, 1'b1, 1'b1, 24'(i), 24'(i * 32'h111111));
      cyc();
    end
    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) cpu(0, 1'b1, 1'b0, 24'(i), 24'h0);
      else quiet();
      #1;
      if (i <= 3) chk("t4_gnt", 0, ogc[0], 32'h1);
      if (i >= 2) begin
        chk("t4_rvalid", 0, orvc[0], 32'h1);
        chk("t4_rdata", 0, ordc[0], 32'((i - 1) * 32'h111111));
      end
      cyc();
    end
    // sustained conflict: dbg forced through after every 4 cpu grants
    quiet();
    cyc();
    pat = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      cpu(0, 1'b1, 1'b1, 24'h40, 24'h123456);
      dbg(0, 1'b1, 1'b1, 24'(32'h60 + i), 24'($urandom));
      #1;
      chk("t3_dbg_gnt", 0, ogd[0], 32'(pat[i]));
      chk("t3_cpu_gnt", 0, ogc[0], 32'(!pat[i]));
      cyc();
    end
    drain();
    cyc();
    // dbg gives up after two losses; the starvation count restarts from zero
    for (int i = 0; i < 2; i++) begin
      cpu(0, 1'b1, 1'b1, 24'h41, 24'h0F0F0F);
      dbg(0, 1'b1, 1'b0, 24'h42, 24'h0);
      #1;
      chk("t6_no_dbg", 0, ogd[0], 32'h0);
      cyc();
    end
    dr[0] = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cpu(0, 1'b1, 1'b1, 24'h41, 24'h0F0F0F);
      dbg(0, 1'b1, 1'b0, 24'h40, 24'h0);
      #1;
      chk("t6_dbg_gnt", 0, ogd[0], 32'(i == 4));
      cyc();
    end
    drain();
    cyc();
    // dbg read at MEM_LAT=3 blocks a cpu read until the dbg rvalid cycle
    cpu(1, 1'b1, 1'b1, 24'h5, 24'h5A5A5A);
    cyc();
    quiet();
    cyc();
    dbg(1, 1'b1, 1'b0, 24'h5, 24'h0);
    #1;
    chk("t5_dbg_gnt", 1, ogd[1], 32'h1);
    cyc();
    dr[1] = 1'b0;
    cpu(1, 1'b1, 1'b0, 24'h5, 24'h0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) quiet();
      #1;
      chk("t5_stall", 1, ostl[1], 32'(k < 6));
      chk("t5_cpu_gnt", 1, ogc[1], 32'(k == 3));
      if (k == 3) chk("t5_dbg_rv", 1, orvd[1], 32'h1);
      if (k == 6) begin
        chk("t5_cpu_rv", 1, orvc[1], 32'h1);
        chk("t5_rdata", 1, ordc[1], 32'h5A5A5A);
      end
      cyc();
    end
    // reset two cycles into a MEM_LAT=3 read: the read is dropped
    cpu(1, 1'b1, 1'b0, 24'h5, 24'h0);
    cyc();
    quiet();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t1_cpu_stall", 1, ostl[1], 32'h0);
    chk("t1_cpu_rvalid", 1, orvc[1], 32'h0);
    chk("t1_mem_en", 1, omen[1], 32'h0);
    chk("t1_mem_addr", 1, omad[1], 32'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_no_rvalid", 1, orvc[1], 32'h0);
      cyc();
    end
    // random traffic on both ports of both DUTs
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (!hold[d]) cpu(d, ($urandom % 4) != 0, 1'($urandom), 24'($urandom % 16), 24'($urandom));
        dbg(d, ($urandom % 3) != 0, 1'($urandom), 24'($urandom % 16), 24'($urandom));
      end
      cyc();
    end
    drain();
    for (int i = 0; i < 4; i++) cyc();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
